// File: rtl/seq_101_frame_tx.sv
// Serial frame transmitter: 101 sync preamble, MSB-first payload, optional even
// parity bit and an idle gap, feeding the 101 sequence detector's input line.
module seq_101_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_EN    = 1,
  parameter int GAP_BITS     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              d_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX0 = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
  localparam int CNT_MAX  = (CNT_MAX0 > 3) ? CNT_MAX0 : 3;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int TICK_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  SYNC_LAST = CNT_W'(2);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] value);
    return ^value;
  endfunction

  state_t              state_r, state_s;
  logic [TICK_W-1:0]   tick_r, tick_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [DATA_W-1:0]   shift_r, shift_s;
  logic                parity_r, parity_s;
  logic                d_out_r, d_out_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                bit_end_s;

  // Next-state and next-output logic; d_out is computed one edge ahead so the line is registered.
  always_comb begin
    state_s   = state_r;
    tick_s    = tick_r;
    cnt_s     = cnt_r;
    shift_s   = shift_r;
    parity_s  = parity_r;
    d_out_s   = d_out_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    bit_end_s = (tick_r == TICK_LAST);

    case (state_r)
      ST_IDLE: begin
        d_out_s = 1'b0;
        busy_s  = 1'b0;
        if (start) begin
          shift_s  = data_in;
          parity_s = even_parity(data_in);
          busy_s   = 1'b1;
          d_out_s  = 1'b1;
          tick_s   = {TICK_W{1'b0}};
          cnt_s    = {CNT_W{1'b0}};
          state_s  = ST_SYNC;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SYNC: begin
        if (!bit_end_s) begin
          tick_s = tick_r + TICK_W'(1);
        end else begin
          tick_s = {TICK_W{1'b0}};
          if (cnt_r == SYNC_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            d_out_s = shift_r[DATA_W-1];
            state_s = ST_DATA;
          end else begin
            // Preamble bit 1 is a 0, bit 2 is a 1.
            cnt_s   = cnt_r + CNT_W'(1);
            d_out_s = cnt_r[0];
          end
        end
      end

      ST_DATA: begin
        if (!bit_end_s) begin
          tick_s = tick_r + TICK_W'(1);
        end else begin
          tick_s  = {TICK_W{1'b0}};
          shift_s = shift_r << 1;
          if (cnt_r == DATA_LAST) begin
            cnt_s = {CNT_W{1'b0}};
            if (PARITY_EN != 0) begin
              d_out_s = parity_r;
              state_s = ST_PARITY;
            end else begin
              d_out_s = 1'b0;
              state_s = ST_GAP;
            end
          end else begin
            cnt_s   = cnt_r + CNT_W'(1);
            d_out_s = shift_s[DATA_W-1];
          end
        end
      end

      ST_PARITY: begin
        if (!bit_end_s) begin
          tick_s = tick_r + TICK_W'(1);
        end else begin
          tick_s  = {TICK_W{1'b0}};
          cnt_s   = {CNT_W{1'b0}};
          d_out_s = 1'b0;
          state_s = ST_GAP;
        end
      end

      ST_GAP: begin
        d_out_s = 1'b0;
        if (!bit_end_s) begin
          tick_s = tick_r + TICK_W'(1);
        end else begin
          tick_s = {TICK_W{1'b0}};
          if (cnt_r == GAP_LAST) begin
            cnt_s   = {CNT_W{1'b0}};
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
      end

      default: begin
        d_out_s = 1'b0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      tick_r   <= {TICK_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      shift_r  <= {DATA_W{1'b0}};
      parity_r <= 1'b0;
      d_out_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      tick_r   <= tick_s;
      cnt_r    <= cnt_s;
      shift_r  <= shift_s;
      parity_r <= parity_s;
      d_out_r  <= d_out_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign d_out = d_out_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule
